// File: rtl/pc_seq_pkg.sv
// Shared state encoding and sizing helpers for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int ADV_CNT_W = 32;

  function automatic int align_bits(input int instr_bytes);
    return $clog2(instr_bytes);
  endfunction

endpackage

// File: rtl/pc_halt_detect.sv
// Counts consecutive self-redirects; halt_hit flags the one that completes HALT_CNT in a row.
module pc_halt_detect #(
  parameter int HALT_CNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic self_hit,
  input  logic other_adv,
  output logic halt_hit
);

  localparam int CW = (HALT_CNT < 2) ? 1 : $clog2(HALT_CNT);
  localparam logic [CW-1:0] LAST = CW'(HALT_CNT - 1);

  logic [CW-1:0] cnt;

  assign halt_hit = self_hit && (cnt == LAST);

  // Stalls assert neither input, so the run length survives them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (self_hit) begin
      if (!halt_hit) cnt <= cnt + CW'(1);
    end else if (other_adv) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register with boot hold, stall/redirect sequencing and self-loop halt detection; PC updates one edge after sampling.
// Define PC_SEQ_TRACE_EN to build the saturating advance counter on adv_cnt_o (tied to 0 otherwise).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter int              INSTR_BYTES = 4,
  parameter int              BOOT_HOLD   = 5,
  parameter int              HALT_CNT    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 redirect_valid_i,
  input  logic [PC_W-1:0]      redirect_pc_i,
  output logic [PC_W-1:0]      PC,
  output logic                 pc_valid_o,
  output logic                 boot_done_o,
  output logic                 halted_o,
  output logic                 misalign_o,
  output logic [ADV_CNT_W-1:0] adv_cnt_o
);

  localparam int              AB         = align_bits(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'((1 << AB) - 1);
  localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSTR_BYTES);
  localparam int              BW         = (BOOT_HOLD < 2) ? 1 : $clog2(BOOT_HOLD);
  localparam logic [BW-1:0]   BOOT_LAST  = BW'(BOOT_HOLD - 1);

  pc_state_t       state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [BW-1:0]   boot_cnt, boot_nxt;
  logic            mis_q, mis_set;
  logic            run, redir_ok, self_hit, adv, other_adv, halt_hit;

  assign run       = (state == RUN);
  assign redir_ok  = run && redirect_valid_i && ((redirect_pc_i & ALIGN_MASK) == '0);
  assign self_hit  = redir_ok && (redirect_pc_i == pc_q);
  assign adv       = redir_ok || (run && !stall_i);
  assign other_adv = adv && !self_hit;

  pc_halt_detect #(
    .HALT_CNT (HALT_CNT)
  ) u_halt_detect (
    .clk       (clk),
    .rst       (rst),
    .self_hit  (self_hit),
    .other_adv (other_adv),
    .halt_hit  (halt_hit)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    boot_nxt  = boot_cnt;
    mis_set   = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_LAST) state_nxt = RUN;
        else                       boot_nxt  = boot_cnt + BW'(1);
      end
      RUN: begin
        // An aligned redirect beats a stall; a misaligned one is dropped and falls through.
        if (redir_ok) begin
          pc_nxt = redirect_pc_i;
        end else begin
          mis_set = redirect_valid_i;
          if (!stall_i) pc_nxt = pc_q + PC_INC;
        end
        if (halt_hit) state_nxt = HALT;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      pc_q     <= RESET_VEC;
      boot_cnt <= '0;
      mis_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      boot_cnt <= boot_nxt;
      mis_q    <= mis_q | mis_set;
    end
  end

  // BOOT is only re-entered through reset, so leaving it is already sticky.
  assign PC          = pc_q;
  assign pc_valid_o  = run;
  assign boot_done_o = (state != BOOT);
  assign halted_o    = (state == HALT);
  assign misalign_o  = mis_q;

`ifdef PC_SEQ_TRACE_EN
  logic [ADV_CNT_W-1:0] adv_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adv_cnt_q <= '0;
    end else if (adv && (adv_cnt_q != '1)) begin
      adv_cnt_q <= adv_cnt_q + ADV_CNT_W'(1);
    end
  end

  assign adv_cnt_o = adv_cnt_q;
`else
  assign adv_cnt_o = '0;
`endif

endmodule
